// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: front-panel controller for a 4-digit time display.
//   Debounces three raw keys, sequences the stopwatch and time-of-day datapaths
//   (mode select, start/reset/increment pulses, set-field select), and muxes the
//   two BCD digit buses onto Hex_0..Hex_3, blinking the field being set.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   key_mode/a/b     raw bouncy keys, active high
//   sw_hex[15:0]     stopwatch digits {d3,d2,d1,d0}, BCD
//   clk_hex[15:0]    clock digits {H1,H0,M1,M0}, BCD
//   mod              0 = stopwatch mode, 1 = clock mode (incl. set states)
//   sw_start         1-cycle pulse: toggle stopwatch run
//   sw_reset         1-cycle pulse: clear stopwatch
//   set_inc          1-cycle pulse: increment the field selected by set_field
//   set_field[1:0]   00 none, 10 hours, 01 minutes
//   Hex_0..Hex_3     displayed digits, 4'hF = blank
//
// Build option: define CLK_AUTO_EXIT_EN to leave the set states back to the
// clock view after AUTO_EXIT_S seconds without any key event.
module clock_mode_ctrl #(
  parameter int unsigned IN_CLK_HZ   = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned BLINK_HZ    = 2,
  parameter int unsigned AUTO_EXIT_S = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_a,
  input  logic        key_b,
  input  logic [15:0] sw_hex,
  input  logic [15:0] clk_hex,
  output logic        mod,
  output logic        sw_start,
  output logic        sw_reset,
  output logic        set_inc,
  output logic [1:0]  set_field,
  output logic [3:0]  Hex_0,
  output logic [3:0]  Hex_1,
  output logic [3:0]  Hex_2,
  output logic [3:0]  Hex_3
);

  localparam int unsigned DbCyc = IN_CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned Hp    = IN_CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned DbW   = $clog2(DbCyc + 1);
  localparam int unsigned HpW   = $clog2(Hp + 1);

  // Key index within the packed key vectors.
  localparam int unsigned KMode = 0;
  localparam int unsigned KA    = 1;
  localparam int unsigned KB    = 2;

  typedef enum logic [1:0] {StWatch, StClock, StSetHh, StSetMm} state_e;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [2:0]     key_raw;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     level_q, level_d;
  logic [DbW-1:0] db_cnt_q [3];
  logic [DbW-1:0] db_cnt_d [3];
  logic [2:0]     key_ev;

  assign key_raw = {key_b, key_a, key_mode};

  // The event fires in the cycle the accepted level rises, so the FSM reacts on
  // the same edge that updates level_q.
  always_comb begin
    level_d = level_q;
    key_ev  = '0;
    for (int k = 0; k < 3; k++) begin
      db_cnt_d[k] = '0;
      if (sync2_q[k] != level_q[k]) begin
        if (db_cnt_q[k] == DbW'(DbCyc - 1)) begin
          level_d[k] = sync2_q[k];
          key_ev[k]  = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DbW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM, blink and display next state
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic           mod_q, mod_d;
  logic           sw_start_q, sw_start_d;
  logic           sw_reset_q, sw_reset_d;
  logic           set_inc_q, set_inc_d;
  logic [1:0]     set_field_q, set_field_d;
  logic [HpW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_off_q, blink_off_d;
  logic [15:0]    hex_q, hex_d;
  logic           idle_timeout;
  logic           in_set_d;

  always_comb begin
    state_d    = state_q;
    sw_start_d = 1'b0;
    sw_reset_d = 1'b0;
    set_inc_d  = 1'b0;

    // mode beats b beats a; losers are dropped, not queued
    if (key_ev[KMode]) begin
      case (state_q)
        StWatch: state_d = StClock;
        StClock: state_d = StSetHh;
        StSetHh: state_d = StSetMm;
        default: state_d = StWatch;
      endcase
    end else if (key_ev[KB]) begin
      case (state_q)
        StWatch: sw_reset_d = 1'b1;
        StSetHh: state_d    = StSetMm;
        StSetMm: state_d    = StClock;
        default: ;
      endcase
    end else if (key_ev[KA]) begin
      case (state_q)
        StWatch:          sw_start_d = 1'b1;
        StSetHh, StSetMm: set_inc_d  = 1'b1;
        default: ;
      endcase
    end else if (idle_timeout) begin
      state_d = StClock;
    end

    in_set_d = (state_d == StSetHh) || (state_d == StSetMm);

    // Blink restarts visible on entering a set state and after every increment.
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (!in_set_d || (state_d != state_q) || set_inc_d) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == HpW'(Hp - 1)) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + HpW'(1);
    end

    mod_d = (state_d != StWatch);
    case (state_d)
      StSetHh: set_field_d = 2'b10;
      StSetMm: set_field_d = 2'b01;
      default: set_field_d = 2'b00;
    endcase

    hex_d = (state_d == StWatch) ? sw_hex : clk_hex;
    if (blink_off_d && (state_d == StSetHh)) hex_d[15:8] = 8'hFF;
    if (blink_off_d && (state_d == StSetMm)) hex_d[7:0]  = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
      state_q     <= StWatch;
      mod_q       <= 1'b0;
      sw_start_q  <= 1'b0;
      sw_reset_q  <= 1'b0;
      set_inc_q   <= 1'b0;
      set_field_q <= 2'b00;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      hex_q       <= '0;
    end else begin
      sync1_q     <= key_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= db_cnt_d[k];
      state_q     <= state_d;
      mod_q       <= mod_d;
      sw_start_q  <= sw_start_d;
      sw_reset_q  <= sw_reset_d;
      set_inc_q   <= set_inc_d;
      set_field_q <= set_field_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      hex_q       <= hex_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Idle timeout in set states
  // ---------------------------------------------------------------------------
`ifdef CLK_AUTO_EXIT_EN
  localparam int unsigned IdleCyc = AUTO_EXIT_S * IN_CLK_HZ;

  logic [31:0] idle_q, idle_d;
  logic        in_set_q;

  assign in_set_q     = (state_q == StSetHh) || (state_q == StSetMm);
  assign idle_timeout = in_set_q && (idle_q == IdleCyc - 1);

  always_comb begin
    idle_d = '0;
    if (in_set_q && (key_ev == '0) && (state_d == state_q)) idle_d = idle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  assign idle_timeout = 1'b0;

  // AUTO_EXIT_S only matters when the timeout is built in.
  logic unused_auto_exit;
  assign unused_auto_exit = ^AUTO_EXIT_S;
`endif

  assign mod       = mod_q;
  assign sw_start  = sw_start_q;
  assign sw_reset  = sw_reset_q;
  assign set_inc   = set_inc_q;
  assign set_field = set_field_q;
  assign Hex_3     = hex_q[15:12];
  assign Hex_2     = hex_q[11:8];
  assign Hex_1     = hex_q[7:4];
  assign Hex_0     = hex_q[3:0];

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl with small timing parameters (DB_CYC=2, HP=5).
// A reference model predicts every output each cycle; directed steps are
// followed by a randomized key/digit phase.
module tb_clock_mode_ctrl;

  localparam int DB = 2;
  localparam int HP = 5;

  // Expected mod / set_field after the n-th mode press starting from the watch view.
  localparam logic [3:0] ModSeq   = 4'b0111;
  localparam logic [7:0] FieldSeq = 8'b00_01_10_00;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_mode, key_a, key_b;
  logic [15:0] sw_hex, clk_hex;
  logic        mod, sw_start, sw_reset, set_inc;
  logic [1:0]  set_field;
  logic [3:0]  hex0, hex1, hex2, hex3;

  always #5 clk = ~clk;

  clock_mode_ctrl #(
    .IN_CLK_HZ  (1000),
    .DEBOUNCE_MS(2),
    .BLINK_HZ   (100),
    .AUTO_EXIT_S(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_mode (key_mode),
    .key_a    (key_a),
    .key_b    (key_b),
    .sw_hex   (sw_hex),
    .clk_hex  (clk_hex),
    .mod      (mod),
    .sw_start (sw_start),
    .sw_reset (sw_reset),
    .set_inc  (set_inc),
    .set_field(set_field),
    .Hex_0    (hex0),
    .Hex_1    (hex1),
    .Hex_2    (hex2),
    .Hex_3    (hex3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: state 0 watch, 1 clock, 2 set hours, 3 set minutes.
  logic [2:0]  hist[$];
  logic [2:0]  m_acc;
  int          m_state;
  int          m_n;
  int          m_origin;
  logic        e_mod, e_start, e_reset, e_inc;
  logic [1:0]  e_field;
  logic [15:0] e_hex;

  int cnt_start, cnt_reset, cnt_inc;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [2:0]  raw;
    logic [2:0]  ev;
    logic        r;
    logic [15:0] sh, ch;
    int          prev;
    bit          diff;
    bit          off;
    raw = {key_b, key_a, key_mode};
    r   = rst;
    sh  = sw_hex;
    ch  = clk_hex;
    @(posedge clk);
    m_n++;
    e_start = 1'b0;
    e_reset = 1'b0;
    e_inc   = 1'b0;
    if (r) begin
      hist.delete();
      m_acc   = '0;
      m_state = 0;
      e_mod   = 1'b0;
      e_field = 2'b00;
      e_hex   = 16'h0000;
    end else begin
      hist.push_back(raw);
      if (hist.size() > 16) void'(hist.pop_front());
      // A key level is accepted once the last DB samples, seen through the
      // 2-stage synchroniser, all differ from the accepted level.
      ev = '0;
      for (int k = 0; k < 3; k++) begin
        diff = (hist.size() >= DB + 2);
        for (int j = 0; j < DB && diff; j++) begin
          if (hist[hist.size() - 3 - j][k] == m_acc[k]) diff = 1'b0;
        end
        if (diff) begin
          m_acc[k] = ~m_acc[k];
          ev[k]    = m_acc[k];
        end
      end
      prev = m_state;
      if (ev[0]) m_state = (m_state + 1) % 4;
      else if (ev[2]) begin
        if (m_state == 0) e_reset = 1'b1;
        else if (m_state == 2) m_state = 3;
        else if (m_state == 3) m_state = 1;
      end else if (ev[1]) begin
        if (m_state == 0) e_start = 1'b1;
        else if (m_state >= 2) e_inc = 1'b1;
      end
      if (m_state >= 2 && (m_state != prev || e_inc)) m_origin = m_n;
      off     = (m_state >= 2) && (((m_n - m_origin) / HP) % 2 == 1);
      e_mod   = (m_state != 0);
      e_field = (m_state == 2) ? 2'b10 : (m_state == 3) ? 2'b01 : 2'b00;
      e_hex   = (m_state == 0) ? sh : ch;
      if (off && m_state == 2) e_hex[15:8] = 8'hFF;
      if (off && m_state == 3) e_hex[7:0]  = 8'hFF;
    end
    #1;
    check("mod", 16'(mod), 16'(e_mod));
    check("set_field", 16'(set_field), 16'(e_field));
    check("sw_start", 16'(sw_start), 16'(e_start));
    check("sw_reset", 16'(sw_reset), 16'(e_reset));
    check("set_inc", 16'(set_inc), 16'(e_inc));
    check("hex", {hex3, hex2, hex1, hex0}, e_hex);
    if (sw_start === 1'b1) cnt_start++;
    if (sw_reset === 1'b1) cnt_reset++;
    if (set_inc === 1'b1) cnt_inc++;
  endtask

  task automatic press(input int k, input int hold, input int gap);
    if (k == 0) key_mode = 1'b1;
    else if (k == 1) key_a = 1'b1;
    else key_b = 1'b1;
    repeat (hold) tick();
    key_mode = 1'b0;
    key_a    = 1'b0;
    key_b    = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulse_at;
    int hold_left [3];
    m_n      = 0;
    m_origin = 0;
    m_state  = 0;
    m_acc    = '0;

    // Reset with all keys idle.
    rst      = 1'b1;
    key_mode = 1'b0;
    key_a    = 1'b0;
    key_b    = 1'b0;
    sw_hex   = 16'h5678;
    clk_hex  = 16'h0000;
    tick();
    check("reset_mod", 16'(mod), 16'h0);
    check("reset_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
    rst = 1'b0;
    tick();
    check("hex_follows_sw", {hex3, hex2, hex1, hex0}, 16'h5678);

    // One-cycle glitch, then a held key: exactly one start pulse.
    cnt_start = 0;
    key_a = 1'b1;
    tick();
    key_a = 1'b0;
    repeat (3) tick();
    key_a    = 1'b1;
    pulse_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sw_start === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    key_a = 1'b0;
    repeat (6) tick();
    check("glitch_then_hold_pulses", 16'(cnt_start), 16'd1);
    check("start_latency", 16'(pulse_at), 16'd4);

    // Walk through all four modes; increment and blink while setting hours.
    for (int i = 0; i < 4; i++) begin
      press(0, 4, 5);
      check("press_mod", 16'(mod), 16'(ModSeq[i]));
      check("press_field", 16'(set_field), 16'(FieldSeq[2*i +: 2]));
      if (i == 1) begin
        clk_hex = 16'h1234;
        for (int j = 0; j < 20; j++) begin
          tick();
          check("hh_minutes_shown", 16'({hex1, hex0}), 16'h0034);
        end
        cnt_inc = 0;
        press(1, 4, 5);
        check("set_inc_count", 16'(cnt_inc), 16'd1);
      end
    end

    // Mode and b together in the watch view: mode wins, reset dropped.
    cnt_reset = 0;
    key_mode  = 1'b1;
    key_b     = 1'b1;
    repeat (4) tick();
    key_mode = 1'b0;
    key_b    = 1'b0;
    repeat (5) tick();
    check("simul_mode_b_mod", 16'(mod), 16'h1);
    check("simul_mode_b_no_reset", 16'(cnt_reset), 16'd0);

    // Into minutes-set, wait for the off phase, then reset.
    press(0, 4, 5);
    press(0, 4, 5);
    check("mm_off_phase", 16'({hex1, hex0}), 16'h00FF);
    cnt_start = 0;
    cnt_reset = 0;
    cnt_inc   = 0;
    sw_hex    = 16'h9012;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_field", 16'(set_field), 16'h0);
    check("rst_mid_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
    tick();
    check("rst_mid_hex_sw", {hex3, hex2, hex1, hex0}, 16'h9012);
    repeat (3) tick();
    check("rst_mid_no_pulses", 16'(cnt_start + cnt_reset + cnt_inc), 16'd0);

    // Randomized keys, digits and occasional resets.
    for (int k = 0; k < 3; k++) hold_left[k] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold_left[k] == 0) begin
          hold_left[k] = int'($urandom_range(1, 8));
          if (k == 0) key_mode = ($urandom_range(0, 3) == 0);
          else if (k == 1) key_a = $urandom_range(0, 1) == 1;
          else key_b = $urandom_range(0, 1) == 1;
        end
        hold_left[k]--;
      end
      sw_hex  = 16'($urandom);
      clk_hex = 16'($urandom);
      rst     = ($urandom_range(0, 255) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
